// File: rtl/rr_arbiter_4x1.sv
// Four-channel round-robin arbiter feeding a one-word registered output slot.
// Define RR_ARBITER_4X1_GNT_CNT_EN to add the saturating gnt_cnt load counter.
module rr_arbiter_4x1 #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic [N-1:0] in3,
    input  logic         out_ready,
    output logic [3:0]   gnt,
    output logic [1:0]   sel,
    output logic [N-1:0] out,
    output logic         out_valid
`ifdef RR_ARBITER_4X1_GNT_CNT_EN
    ,
    output logic [15:0]  gnt_cnt
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [1:0]   ptr_q;
    logic [7:0]   req_sh;
    logic [3:0]   rot;
    logic [1:0]   off;
    logic [1:0]   win;
    logic         slot;
    logic         take;
    logic [N-1:0] din;

    // rot[j] is the request of channel ptr+j, so the lowest set bit wins
    always_comb begin
        req_sh = {req, req} >> ptr_q;
        rot    = req_sh[3:0];
        off    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rot[i]) off = 2'(i);
        end
        win = ptr_q + off;
    end

    always_comb begin
        din = in0;
        unique case (win)
            2'd0: din = in0;
            2'd1: din = in1;
            2'd2: din = in2;
            2'd3: din = in3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        gnt     = 4'b0000;
        take    = 1'b0;
        slot    = (state_q == EMPTY) || out_ready;
        if (!rst && slot) begin
            if (|req) begin
                take    = 1'b1;
                gnt     = 4'(1) << win;
                state_d = FULL;
            end else begin
                state_d = EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    // Reset drops any held word; it is never delivered
    always_ff @(posedge clk) begin
        if (rst) begin
            out   <= '0;
            sel   <= 2'd0;
            ptr_q <= 2'd0;
        end else if (take) begin
            out   <= din;
            sel   <= win;
            ptr_q <= win + 2'd1;
        end
    end

    assign out_valid = (state_q == FULL);

`ifdef RR_ARBITER_4X1_GNT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)                             gnt_cnt <= 16'd0;
        else if (take && gnt_cnt != 16'hFFFF) gnt_cnt <= gnt_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_rr_arbiter_4x1.sv
// Self-checking bench for rr_arbiter_4x1: directed scenarios plus randomized
// traffic against a queue-free behavioural model of the round-robin slot.
module tb_rr_arbiter_4x1;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [N-1:0] ins [4];
    logic         out_ready;
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic [N-1:0] out;
    logic         out_valid;
`ifdef RR_ARBITER_4X1_GNT_CNT_EN
    logic [15:0]  gnt_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Model state
    bit           m_full;
    logic [N-1:0] m_out;
    int           m_sel;
    int           m_ptr;
    int           m_cnt;

    always #5 clk = ~clk;

    rr_arbiter_4x1 #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in0       (ins[0]),
        .in1       (ins[1]),
        .in2       (ins[2]),
        .in3       (ins[3]),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .out       (out),
        .out_valid (out_valid)
`ifdef RR_ARBITER_4X1_GNT_CNT_EN
        ,
        .gnt_cnt   (gnt_cnt)
`endif
    );

    // First requesting channel walking ptr, ptr+1, ... mod 4; -1 if none
    function automatic int model_winner();
        for (int k = 0; k < 4; k++) begin
            if (req[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_gnt();
        int w;
        w = model_winner();
        if (rst) return 4'b0000;
        if ((m_full && !out_ready) || w < 0) return 4'b0000;
        return 4'(1 << w);
    endfunction

    task automatic step();
        int w;
        @(posedge clk);
        w = model_winner();
        if (rst) begin
            m_full = 0; m_out = '0; m_sel = 0; m_ptr = 0; m_cnt = 0;
        end else if (!m_full || out_ready) begin
            if (w >= 0) begin
                m_out  = ins[w];
                m_sel  = w;
                m_ptr  = (w + 1) % 4;
                m_full = 1;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_full = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'h0; out_ready = 1'b0;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'hF; out_ready = 1'b1;
        ins[0] = 4'h1; ins[1] = 4'h2; ins[2] = 4'h3; ins[3] = 4'h4;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (gnt !== 4'b0000) begin
                errors++;
                $display("FAIL reset_gnt got %b want 0000", gnt);
            end
            step();
            checks++;
            if (out_valid !== 1'b0 || out !== 4'h0 || sel !== 2'd0) begin
                errors++;
                $display("FAIL reset_regs got v=%b out=%h sel=%0d want 0/0/0",
                         out_valid, out, sel);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_gnt got %b want 0001", gnt);
        end
        step();
    endtask

    task automatic test_rotation();
        logic [3:0] eg [5];
        logic [3:0] eo [5];
        int         es [5];
        eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        eo = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
        es = '{0, 1, 2, 3, 0};
        do_reset();
        ins[0] = 4'h1; ins[1] = 4'h2; ins[2] = 4'h3; ins[3] = 4'h4;
        req = 4'hF; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (gnt !== eg[i]) begin
                errors++;
                $display("FAIL rot_gnt[%0d] got %b want %b", i, gnt, eg[i]);
            end
            step();
            checks++;
            if (out !== eo[i] || sel !== 2'(es[i]) || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL rot_out[%0d] got out=%h sel=%0d v=%b want %h/%0d/1",
                         i, out, sel, out_valid, eo[i], es[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ins[2] = 4'hA;
        req = 4'b0100; out_ready = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL bp_load_gnt got %b want 0100", gnt);
        end
        step();
        req = 4'hF; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (gnt !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold_gnt[%0d] got %b want 0000", c, gnt);
            end
            step();
            checks++;
            if (out !== 4'hA || sel !== 2'd2 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d] got out=%h sel=%0d v=%b want A/2/1",
                         c, out, sel, out_valid);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL bp_release_gnt got %b want 1000", gnt);
        end
        step();
        checks++;
        if (sel !== 2'd3 || out !== ins[3]) begin
            errors++;
            $display("FAIL bp_release got sel=%0d out=%h want 3/%h", sel, out, ins[3]);
        end
    endtask

    task automatic test_skip();
        do_reset();
        req = 4'b0001; out_ready = 1'b1;
        step();
        req = 4'b1001;
        #1;
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL skip_gnt got %b want 1000", gnt);
        end
        step();
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL skip_wrap_gnt got %b want 0001", gnt);
        end
        step();
        checks++;
        if (sel !== 2'd0) begin
            errors++;
            $display("FAIL skip_wrap_sel got %0d want 0", sel);
        end
    endtask

    task automatic test_drain();
        do_reset();
        req = 4'b0001; out_ready = 1'b1;
        step();
        req = 4'b0000;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_valid got %b want 0", out_valid);
        end
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (gnt !== 4'b0000) begin
                errors++;
                $display("FAIL drain_idle_gnt[%0d] got %b want 0000", c, gnt);
            end
            step();
            checks++;
            if (out_valid !== 1'b0 || out !== ins[0] || sel !== 2'd0) begin
                errors++;
                $display("FAIL drain_idle[%0d] got v=%b out=%h sel=%0d want 0/%h/0",
                         c, out_valid, out, sel, ins[0]);
            end
        end
        req = 4'hF;
        #1;
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL drain_ptr_gnt got %b want 0010", gnt);
        end
        step();
    endtask

    task automatic test_random();
        logic [3:0] eg;
        for (int c = 0; c < 1500; c++) begin
            rst       = ($urandom_range(0, 49) == 0);
            req       = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++) ins[k] = N'($urandom);
            #1;
            eg = model_gnt();
            checks++;
            if (gnt !== eg || $countones(gnt) > 1) begin
                errors++;
                $display("FAIL rand_gnt[%0d] got %b want %b", c, gnt, eg);
            end
            step();
            checks++;
            if (out_valid !== m_full || out !== m_out || sel !== 2'(m_sel)) begin
                errors++;
                $display("FAIL rand_out[%0d] got v=%b out=%h sel=%0d want %b/%h/%0d",
                         c, out_valid, out, sel, m_full, m_out, m_sel);
            end
`ifdef RR_ARBITER_4X1_GNT_CNT_EN
            checks++;
            if (gnt_cnt !== 16'(m_cnt)) begin
                errors++;
                $display("FAIL rand_cnt[%0d] got %0d want %0d", c, gnt_cnt, m_cnt);
            end
`endif
        end
        rst = 1'b0;
    endtask

`ifdef RR_ARBITER_4X1_GNT_CNT_EN
    task automatic test_counter();
        do_reset();
        req = 4'hF; out_ready = 1'b1;
        for (int c = 0; c < 65540; c++) step();
        checks++;
        if (gnt_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_sat got %h want FFFF", gnt_cnt);
        end
        for (int c = 0; c < 3; c++) step();
        checks++;
        if (gnt_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_hold got %h want FFFF", gnt_cnt);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (gnt_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL cnt_clear got %h want 0000", gnt_cnt);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; req = 4'h0; out_ready = 1'b0;
        for (int k = 0; k < 4; k++) ins[k] = '0;
        m_full = 0; m_out = '0; m_sel = 0; m_ptr = 0; m_cnt = 0;
        #2;
        test_reset();
        test_rotation();
        test_backpressure();
        test_skip();
        test_drain();
        test_random();
`ifdef RR_ARBITER_4X1_GNT_CNT_EN
        test_counter();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_4x1.md
RR_ARBITER_4X1 -- requirements
Module: rr_arbiter_4x1

Interface
REQ-001 Parameter N SHALL default to 4 and SHALL set the width in bits of every data port.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit, SHALL be the reset: synchronous, active-high.
REQ-004 Port req, input, 4 bits, SHALL carry req[k], meaning channel k holds a valid word.
REQ-005 Ports in0, in1, in2, in3, input, N bits each, SHALL carry the channel 0..3 data words.
REQ-006 Port out_ready, input, 1 bit, SHALL mean the downstream consumer accepts out this cycle.
REQ-007 Port gnt, output, 4 bits, SHALL be a combinational one-hot or zero vector; gnt[k]=1 means channel k's word is taken this cycle.
REQ-008 Port sel, output, 2 bits, SHALL be the registered index of the channel whose word is in out.
REQ-009 Port out, output, N bits, SHALL be the registered selected data word.
REQ-010 Port out_valid, output, 1 bit, SHALL be 1 when out holds an undelivered word.

Function
REQ-011 The block SHALL implement a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-012 A load slot SHALL exist when the state is EMPTY, or when the state is FULL and out_ready=1.
REQ-013 In a load slot with req!=0, the block SHALL search channels ptr, ptr+1, ... mod 4 and SHALL pick the first one with req set as winner w.
REQ-014 In that slot, gnt SHALL be one-hot on w; at the clock edge out SHALL load in_w, sel SHALL load w, out_valid SHALL become 1, and ptr SHALL become (w+1) mod 4, so channel 3 wraps to channel 0.
REQ-015 Latency SHALL be 1 cycle from grant to out_valid, with a sustained throughput of 1 word per cycle.
REQ-016 Transition FULL to EMPTY SHALL occur only when out_ready=1 and req=0.
REQ-017 Transition FULL to FULL with a new word SHALL occur when out_ready=1 and req!=0, with the accept and the load in the same cycle.
REQ-018 In FULL with out_ready=0, gnt SHALL be 0, and out, sel and ptr SHALL hold stable.
REQ-019 Transition EMPTY to EMPTY SHALL occur when req=0, with gnt=0 and ptr unchanged.
REQ-020 out_ready in EMPTY SHALL be ignored.
REQ-021 req SHALL need no hold: a channel whose request is not granted may drop it without side effect.
REQ-022 gnt SHALL never have more than one bit set.

Reset
REQ-023 While rst=1 at a clock edge, the block SHALL apply: state to EMPTY, out_valid to 0, out to 0, sel to 0, ptr to 0, and the counter (if present) to 0.
REQ-024 While rst=1, gnt SHALL be forced to 0.
REQ-025 Reset asserted in FULL SHALL discard the held word without delivery.

Configuration
REQ-026 With macro RR_ARBITER_4X1_GNT_CNT_EN defined, the block SHALL add output port gnt_cnt, 16 bits, counting words loaded into out; the count SHALL saturate at 16'hFFFF and be cleared by rst.
REQ-027 Without RR_ARBITER_4X1_GNT_CNT_EN, gnt_cnt and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 Reset scenario: apply rst for 2 cycles with req=4'hF -> gnt=0, out_valid=0, out=0, sel=0 during reset; first cycle after reset grants channel 0.
REQ-029 Rotation scenario: N=4, req=4'hF constant, in0..in3=1,2,3,4, out_ready=1 -> gnt sequence 0001, 0010, 0100, 1000, 0001; out sequence 1,2,3,4,1 one cycle later; sel sequence 0,1,2,3,0.
REQ-030 Backpressure scenario: load in2=4'hA via req=4'b0100, then out_ready=0 for 3 cycles with req=4'hF -> gnt=0, out=4'hA, sel=2 held; on out_ready=1, channel 3 is granted (ptr=3).
REQ-031 Skip scenario: ptr=1, req=4'b1001 -> channel 3 granted, then next grant goes to channel 0, exercising wrap-around.
REQ-032 Drain scenario: FULL, out_ready=1, req=0 -> out_valid=0 next cycle; out_ready held 1 in EMPTY causes no change.
REQ-033 Counter scenario (with RR_ARBITER_4X1_GNT_CNT_EN): preload via 65540 continuous grants -> gnt_cnt=16'hFFFF and stays there; rst -> gnt_cnt=0.
